// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp pattern generator.
//   NLANE_DEF  - default number of lanes per output word
//   LANE_W_DEF - default bits per lane
//   STEP       - per-word base increment for the default configuration (equals NLANE)
//   ramp_state_e - generator FSM states
package ramp_pkg;

  localparam int unsigned NLANE_DEF  = 8;
  localparam int unsigned LANE_W_DEF = 10;
  localparam int unsigned STEP       = NLANE_DEF;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } ramp_state_e;

endpackage

// File: rtl/ramp_word_build.sv
// Combinational expansion of a lane-0 base value into an NLANE-lane ramp word.
//   base - lane-0 value
//   word - lane i = (base + i) mod 2^LANE_W, lane i at bits [LANE_W*(i+1)-1 : LANE_W*i]
module ramp_word_build import ramp_pkg::*; #(
  parameter int unsigned NLANE  = NLANE_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0]       base,
  output logic [NLANE*LANE_W-1:0] word
);

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    assign word[i*LANE_W +: LANE_W] = base + LANE_W'(i);
  end

endmodule

// File: rtl/ramp_pattern_gen.sv
// Ramp pattern generator: emits one NLANE-lane ramp word per cycle while running,
// either continuously or for a finite burst. All outputs are registered.
//   clk, rst (sync, active-high)
//   start/stop        - single-cycle run control
//   burst_mode/len    - finite burst select and length, sampled on accepted start
//   seed              - lane-0 value of the first word, sampled on accepted start
//   inject_err        - request to flip bit 0 of lane 0 of the next emitted word
//   dout/dout_valid   - ramp word and its valid strobe
//   busy/done         - running flag, single-cycle end-of-run pulse
//   word_cnt/inj_cnt  - words since accepted start (saturating), injections since reset
// Error injection is only built when RAMP_GEN_ERR_INJECT_EN is defined.
module ramp_pattern_gen import ramp_pkg::*; #(
  parameter int unsigned NLANE  = NLANE_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    burst_mode,
  input  logic [31:0]             burst_len,
  input  logic [LANE_W-1:0]       seed,
  input  logic                    inject_err,
  output logic [NLANE*LANE_W-1:0] dout,
  output logic                    dout_valid,
  output logic                    busy,
  output logic                    done,
  output logic [63:0]             word_cnt,
  output logic [31:0]             inj_cnt
);

  ramp_state_e             state_q;
  logic                    burst_q;
  logic [31:0]             remain_q;  // words still to emit after the current one
  logic [LANE_W-1:0]       base_q;    // lane-0 value of the next word
  logic [NLANE*LANE_W-1:0] dout_q;
  logic                    valid_q;
  logic                    done_q;
  logic [63:0]             wcnt_q;
  logic [63:0]             wcnt_d;
  logic [31:0]             inj_cnt_q;
  logic                    pend_q;

  logic                    accept;
  logic                    zero_burst;
  logic                    run_end;
  logic                    emit;
  logic                    inj_eff;
  logic [LANE_W-1:0]       build_base;
  logic [NLANE*LANE_W-1:0] word_nxt;

  // Simultaneous start and stop in IDLE cancel each other.
  assign accept     = (state_q == StIdle) && start && !stop;
  assign zero_burst = burst_mode && (burst_len == '0);
  assign run_end    = (state_q == StRun) && (stop || (burst_q && remain_q == '0));
  assign emit       = (accept && !zero_burst) || ((state_q == StRun) && !run_end);
  // The first word of a run comes straight from seed.
  assign build_base = (state_q == StIdle) ? seed : base_q;

`ifdef RAMP_GEN_ERR_INJECT_EN
  // A request arriving on the emitting cycle itself applies to that word.
  assign inj_eff = pend_q | inject_err;
`else
  logic unused_inject_err;
  assign unused_inject_err = inject_err;
  assign inj_eff           = 1'b0;
`endif

  ramp_word_build #(
    .NLANE  (NLANE),
    .LANE_W (LANE_W)
  ) u_word_build (
    .base (build_base),
    .word (word_nxt)
  );

  always_comb begin
    wcnt_d = accept ? '0 : wcnt_q;
    if (emit && wcnt_d != '1) begin
      wcnt_d = wcnt_d + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      burst_q   <= 1'b0;
      remain_q  <= '0;
      base_q    <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wcnt_q    <= '0;
      inj_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= emit;
      wcnt_q  <= wcnt_d;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            burst_q  <= burst_mode;
            remain_q <= burst_len - 32'd1;
            if (zero_burst) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (run_end) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            remain_q <= remain_q - 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (emit) begin
        dout_q <= word_nxt ^ {{(NLANE*LANE_W-1){1'b0}}, inj_eff};
        base_q <= build_base + LANE_W'(NLANE);
        pend_q <= 1'b0;
        if (inj_eff) begin
          inj_cnt_q <= inj_cnt_q + 32'd1;
        end
      end else begin
        pend_q <= inj_eff;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q == StRun);
  assign done       = done_q;
  assign word_cnt   = wcnt_q;
  assign inj_cnt    = inj_cnt_q;

endmodule

// File: tb/tb_ramp_pattern_gen.sv
// Self-checking bench for ramp_pattern_gen: directed vector table, hand-written
// multi-cycle sequences, then randomized stimulus against a word-index reference model.
module tb_ramp_pattern_gen;
  import ramp_pkg::*;

  localparam int NL = 8;
  localparam int LW = 10;
  localparam int MODV = 1 << LW;
`ifdef RAMP_GEN_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, start, stop, burst_mode, inject_err;
  logic [31:0]        burst_len;
  logic [LW-1:0]      seed;
  logic [NL*LW-1:0]   dout;
  logic               dout_valid, busy, done;
  logic [63:0]        word_cnt;
  logic [31:0]        inj_cnt;

  always #5 clk = ~clk;

  ramp_pattern_gen #(
    .NLANE  (NL),
    .LANE_W (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .burst_mode (burst_mode),
    .burst_len  (burst_len),
    .seed       (seed),
    .inject_err (inject_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt),
    .inj_cnt    (inj_cnt)
  );

  typedef struct {
    string           name;
    bit              rst, start, stop, mode, inj;
    int unsigned     len;
    int              seed;
    bit              ev, eb, ed, ez, ecor;
    int              el0;
    longint unsigned ewc;
    int unsigned     einj;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string name, bit r, bit s, bit p, bit m, int unsigned len,
                              int sd, bit inj, bit ev, bit eb, bit ed, bit ez, bit ecor,
                              int el0, longint unsigned ewc, int unsigned einj);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.stop = p; v.mode = m; v.len = len;
    v.seed = sd; v.inj = inj; v.ev = ev; v.eb = eb; v.ed = ed; v.ez = ez; v.ecor = ecor;
    v.el0 = el0; v.ewc = ewc; v.einj = einj;
    return v;
  endfunction

  function automatic logic [NL*LW-1:0] ramp_word(int l0, bit cor);
    logic [NL*LW-1:0] w;
    for (int i = 0; i < NL; i++) w[i*LW +: LW] = LW'((l0 + i) % MODV);
    w[0] = w[0] ^ cor;
    return w;
  endfunction

  task automatic apply(input vec_t v);
    logic [NL*LW-1:0] exp_dout;
    @(negedge clk);
    rst = v.rst; start = v.start; stop = v.stop; burst_mode = v.mode;
    burst_len = v.len; seed = LW'(v.seed); inject_err = v.inj;
    @(posedge clk);
    #1;
    exp_dout = v.ez ? '0 : ramp_word(v.el0, v.ecor);
    n_vec++;
    if (dout !== exp_dout || dout_valid !== v.ev || busy !== v.eb || done !== v.ed ||
        word_cnt !== 64'(v.ewc) || inj_cnt !== v.einj) begin
      n_err++;
      $display("FAIL %s: got dout=%h v=%b b=%b d=%b wc=%0d inj=%0d, exp dout=%h v=%b b=%b d=%b wc=%0d inj=%0d",
               v.name, dout, dout_valid, busy, done, word_cnt, inj_cnt,
               exp_dout, v.ev, v.eb, v.ed, v.ewc, v.einj);
    end
  endtask

  // Reference model: tracks the run's seed and the index of the word on dout.
  bit              m_run, m_valid, m_done, m_zero, m_cor, m_pend, m_burst;
  int              m_seed, m_l0;
  int unsigned     m_len, m_k, m_inj;
  longint unsigned m_wc;

  task automatic model_step(input vec_t v);
    bit emitted = 1'b0;
    bit eff;
    if (v.rst) begin
      m_run = 0; m_valid = 0; m_done = 0; m_zero = 1; m_cor = 0; m_pend = 0;
      m_l0 = 0; m_wc = 0; m_inj = 0;
      return;
    end
    m_done = 0;
    if (!m_run) begin
      m_valid = 0;
      if (v.start && !v.stop) begin
        m_wc = 0; m_seed = v.seed; m_burst = v.mode; m_len = v.len; m_k = 0;
        if (m_burst && m_len == 0) m_done = 1;
        else begin m_run = 1; emitted = 1; end
      end
    end else if (v.stop || (m_burst && m_k == m_len)) begin
      m_run = 0; m_valid = 0; m_done = 1;
    end else begin
      emitted = 1;
    end
    eff = INJ && (m_pend || v.inj);
    if (emitted) begin
      m_k++;
      m_l0 = (m_seed + NL * (m_k - 1)) % MODV;
      m_valid = 1; m_zero = 0; m_wc++;
      m_cor = eff;
      if (eff) m_inj++;
      m_pend = 0;
    end else begin
      m_pend = eff;
    end
  endtask

  initial begin
    vec_t v;
    rst = 1; start = 0; stop = 0; burst_mode = 0; burst_len = 0; seed = '0; inject_err = 0;

    //           name   rst st sp md len  seed inj ev eb ed ez cor l0   wc inj
    tbl.push_back(mk("reset",   1,0,0,0,0,0,0,    0,0,0,1,0,0,    0,0));
    tbl.push_back(mk("idle",    0,0,0,0,0,0,0,    0,0,0,1,0,0,    0,0));
    tbl.push_back(mk("b4_w1",   0,1,0,1,4,0,0,    1,1,0,0,0,0,    1,0));
    tbl.push_back(mk("b4_w2",   0,0,0,0,0,0,0,    1,1,0,0,0,8,    2,0));
    tbl.push_back(mk("b4_w3",   0,0,0,0,0,0,0,    1,1,0,0,0,16,   3,0));
    tbl.push_back(mk("b4_w4",   0,0,0,0,0,0,0,    1,1,0,0,0,24,   4,0));
    tbl.push_back(mk("b4_done", 0,0,0,0,0,0,0,    0,0,1,0,0,24,   4,0));
    tbl.push_back(mk("b4_after",0,0,0,0,0,0,0,    0,0,0,0,0,24,   4,0));
    tbl.push_back(mk("wrap_w1", 0,1,0,0,0,1012,0, 1,1,0,0,0,1012, 1,0));
    tbl.push_back(mk("wrap_w2", 0,0,0,0,0,0,0,    1,1,0,0,0,1020, 2,0));
    tbl.push_back(mk("wrap_w3", 0,0,0,0,0,0,0,    1,1,0,0,0,4,    3,0));
    tbl.push_back(mk("st_inrun",0,1,0,1,1,500,0,  1,1,0,0,0,12,   4,0));
    tbl.push_back(mk("stop",    0,0,1,0,0,0,0,    0,0,1,0,0,12,   4,0));
    tbl.push_back(mk("stop_aft",0,0,0,0,0,0,0,    0,0,0,0,0,12,   4,0));
    tbl.push_back(mk("st_sp",   0,1,1,0,0,100,0,  0,0,0,0,0,12,   4,0));
    tbl.push_back(mk("len0",    0,1,0,1,0,100,0,  0,0,1,0,0,12,   0,0));
    tbl.push_back(mk("len0_aft",0,0,0,0,0,0,0,    0,0,0,0,0,12,   0,0));
    tbl.push_back(mk("rb_w1",   0,1,0,1,3,1000,0, 1,1,0,0,0,1000, 1,0));
    tbl.push_back(mk("rb_rst",  1,1,0,1,3,50,0,   0,0,0,1,0,0,    0,0));
    tbl.push_back(mk("rs_w1",   0,1,0,1,2,7,0,    1,1,0,0,0,7,    1,0));
    tbl.push_back(mk("rs_w2",   0,0,0,0,0,0,0,    1,1,0,0,0,15,   2,0));
    tbl.push_back(mk("rs_done", 0,0,0,0,0,0,0,    0,0,1,0,0,15,   2,0));
    foreach (tbl[i]) apply(tbl[i]);

    // Continuous run stopped while the 10th word is on dout.
    apply(mk("s10_w1", 0,1,0,0,0,5,0, 1,1,0,0,0,5, 1,0));
    for (int k = 2; k <= 10; k++)
      apply(mk("s10_wk", 0,0,0,0,0,0,0, 1,1,0,0,0,5 + NL * (k - 1), longint'(k), 0));
    apply(mk("s10_stop", 0,0,1,0,0,0,0, 0,0,1,0,0,77, 10,0));
    apply(mk("s10_aft",  0,0,0,0,0,0,0, 0,0,0,0,0,77, 10,0));

    // Injection requested while word 5 is shown corrupts word 6 only.
    apply(mk("inj_w1", 0,1,0,0,0,0,0, 1,1,0,0,0,0, 1,0));
    for (int k = 2; k <= 5; k++)
      apply(mk("inj_wk", 0,0,0,0,0,0,0, 1,1,0,0,0,NL * (k - 1), longint'(k), 0));
    apply(mk("inj_w6", 0,0,0,0,0,0,1, 1,1,0,0,INJ,40, 6,INJ));
    apply(mk("inj_w7", 0,0,0,0,0,0,0, 1,1,0,0,0,48, 7,INJ));
    apply(mk("inj_stp",0,0,1,0,0,0,0, 0,0,1,0,0,48, 7,INJ));
    // Two requests before a single word count once.
    apply(mk("inj_r1", 0,0,0,0,0,0,1, 0,0,0,0,0,48, 7,INJ));
    apply(mk("inj_r2", 0,0,0,0,0,0,1, 0,0,0,0,0,48, 7,INJ));
    apply(mk("inj_dw", 0,1,0,1,1,3,0, 1,1,0,0,INJ,3, 1,2*INJ));
    apply(mk("inj_dd", 0,0,0,0,0,0,0, 0,0,1,0,INJ,3, 1,2*INJ));

    // Randomized phase against the reference model.
    v = mk("rnd_rst", 1,0,0,0,0,0,0, 0,0,0,1,0,0,0,0);
    model_step(v);
    apply(v);
    for (int n = 0; n < 3000; n++) begin
      v.name  = "rnd";
      v.rst   = ($urandom % 200) == 0;
      v.start = ($urandom % 6) == 0;
      v.stop  = ($urandom % 25) == 0;
      v.mode  = $urandom % 2;
      v.len   = $urandom % 12;
      v.seed  = int'($urandom % MODV);
      v.inj   = ($urandom % 10) == 0;
      model_step(v);
      v.ev = m_valid; v.eb = m_run; v.ed = m_done; v.ez = m_zero; v.ecor = m_cor;
      v.el0 = m_l0; v.ewc = m_wc; v.einj = m_inj;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ramp_pattern_gen.md
RAMP_PATTERN_GEN -- requirements
Module: ramp_pattern_gen

Interface
REQ-001 SHALL have parameter NLANE, default 8: number of parallel lanes per output word.
REQ-002 SHALL have parameter LANE_W, default 10: bits per lane.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a run.
REQ-006 SHALL have port stop  input  1  single-cycle request to abort a run.
REQ-007 SHALL have port burst_mode  input  1  1 = finite burst, 0 = continuous; sampled on accepted start.
REQ-008 SHALL have port burst_len  input  32  words per burst; sampled on accepted start.
REQ-009 SHALL have port seed  input  LANE_W  lane-0 value of the first word; sampled on accepted start.
REQ-010 SHALL have port inject_err  input  1  single-cycle error-injection request.
REQ-011 SHALL have port dout  output  NLANE*LANE_W  ramp word; lane i occupies bits [LANE_W*(i+1)-1 : LANE_W*i].
REQ-012 SHALL have port dout_valid  output  1  dout carries a new word this cycle.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  single-cycle pulse at run end.
REQ-015 SHALL have port word_cnt  output  64  words emitted since last accepted start.
REQ-016 SHALL have port inj_cnt  output  32  errors injected since reset.

Function
REQ-017 SHALL implement FSM states IDLE and RUN.
REQ-018 SHALL move IDLE->RUN on start; SHALL ignore start while in RUN.
REQ-019 SHALL move RUN->IDLE on stop, or, in burst mode, after the burst_len-th word; done SHALL pulse on the cycle after the last word.
REQ-020 SHALL, when start and stop occur in the same cycle in IDLE, stay in IDLE and produce no done pulse.
REQ-021 SHALL, on start with burst_mode=1 and burst_len=0, emit no words and pulse done one cycle later.
REQ-022 SHALL emit the first word on the cycle after start, with base = seed.
REQ-023 SHALL drive dout_valid high on every RUN cycle; one word per cycle.
REQ-024 SHALL form the word as lane i = (base + i) mod 2^LANE_W.
REQ-025 SHALL advance base by NLANE modulo 2^LANE_W per emitted word (defaults: 1016 -> 0).
REQ-026 SHALL hold dout and base when dout_valid is low.
REQ-027 SHALL increment word_cnt per emitted word; SHALL clear it on accepted start; SHALL saturate it at all-ones.
REQ-028 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on rst, enter IDLE and set dout=0, dout_valid=0, busy=0, done=0, word_cnt=0, inj_cnt=0, base=0, pending injection cleared.
REQ-030 SHALL let rst mid-run abort without a done pulse; rst SHALL win over all simultaneous inputs.

Configuration
REQ-031 SHALL compile in error injection only when RAMP_GEN_ERR_INJECT_EN is defined.
REQ-032 SHALL, with RAMP_GEN_ERR_INJECT_EN defined, latch inject_err and XOR lane 0 of the next emitted word with 1; base progression unaffected; inj_cnt +1 per corrupted word; multiple requests before one word count as one.
REQ-033 SHALL, without RAMP_GEN_ERR_INJECT_EN, ignore inject_err and hold inj_cnt at 0.

Structure
REQ-034 SHALL place NLANE/LANE_W defaults, STEP (=NLANE) and the FSM state typedef in shared package ramp_pkg.
REQ-035 SHALL use one sub-module, ramp_word_build: combinational expansion of base into the NLANE-lane word.

Verification
REQ-036 SHALL cover: seed=0, burst_len=4, burst_mode=1 -> lane-0 values 0,8,16,24; lane i = lane0+i; done 1 cycle after 4th word; word_cnt=4.
REQ-037 SHALL cover: seed=1012, continuous -> word 1 = 1012..1019; word 2 = 1020..1023,0..3; word 3 = 4..11.
REQ-038 SHALL cover: continuous run, stop after 10 words -> busy low, dout_valid low, done pulse, dout holds last word, word_cnt=10.
REQ-039 SHALL cover: start+stop same cycle in IDLE -> no words, no done; start during RUN -> ignored, sequence uninterrupted.
REQ-040 SHALL cover, with macro: inject_err at word 5 -> word 6 lane 0 off by XOR 1, word 7 correct, inj_cnt=1; without macro -> no corruption, inj_cnt=0.
REQ-041 SHALL cover: rst asserted mid-burst -> next cycle all outputs 0, no done; new start restarts from new seed.
